seq_detect_param: RTL

SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

---
 rtl/seq_detect_param.sv | 94 +++++++++
 1 files changed

// File: rtl/seq_detect_param.sv
// Serial bit-pattern detector with a loadable pattern, optional overlap,
// Moore or Mealy match output, and a saturating match counter.
module seq_detect_param #(
    parameter int              PAT_W    = 4,
    parameter logic [PAT_W-1:0] PAT_INIT = PAT_W'(4'b1011),
    parameter int              OVERLAP  = 1,
    parameter int              MEALY    = 0,
    parameter int              CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             x,
    input  logic             pat_load,
    input  logic [PAT_W-1:0] pat_in,
    input  logic             cnt_clr,
    output logic             y,
    output logic [CNT_W-1:0] match_cnt,
    output logic             cnt_sat
);

    localparam int               FILL_W   = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W);
    localparam logic [FILL_W-1:0] FILL_THR = FILL_W'(PAT_W - 1);
    localparam logic [CNT_W-1:0]  CNT_ONES = {CNT_W{1'b1}};

    logic [PAT_W-1:0]  pat_q, pat_d;
    // Only the newest PAT_W-1 history bits ever take part in a comparison.
    logic [PAT_W-2:0]  hist_q, hist_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              y_q, y_d;
    logic [PAT_W-1:0]  cand_s;
    logic              hit_s;

    assign cand_s = {hist_q, x};
    assign hit_s  = in_valid & ~pat_load & (fill_q >= FILL_THR) & (cand_s == pat_q);

    // Next-state logic for pattern, history, fill, counter and Moore output.
    always_comb begin
        pat_d  = pat_q;
        hist_d = hist_q;
        fill_d = fill_q;
        cnt_d  = cnt_q;
        y_d    = hit_s;

        if (pat_load) begin
            pat_d  = pat_in;
            hist_d = {(PAT_W-1){1'b0}};
            fill_d = {FILL_W{1'b0}};
        end else if (in_valid) begin
            hist_d = cand_s[PAT_W-2:0];
            if (hit_s && (OVERLAP == 0)) begin
                fill_d = {FILL_W{1'b0}};
            end else if (fill_q != FILL_MAX) begin
                fill_d = fill_q + FILL_W'(1'b1);
            end else begin
                fill_d = fill_q;
            end
        end else begin
            hist_d = hist_q;
        end

        if (cnt_clr) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (hit_s && (cnt_q != CNT_ONES)) begin
            cnt_d = cnt_q + CNT_W'(1'b1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pat_q  <= PAT_INIT;
            hist_q <= {(PAT_W-1){1'b0}};
            fill_q <= {FILL_W{1'b0}};
            cnt_q  <= {CNT_W{1'b0}};
            y_q    <= 1'b0;
        end else begin
            pat_q  <= pat_d;
            hist_q <= hist_d;
            fill_q <= fill_d;
            cnt_q  <= cnt_d;
            y_q    <= y_d;
        end
    end

    assign y         = (MEALY != 0) ? hit_s : y_q;
    assign match_cnt = cnt_q;
    assign cnt_sat   = (cnt_q == CNT_ONES);

endmodule
